// File: rtl/mult_arbiter.sv
// Arbiter sharing one pipelined signed 32x32->64 multiplier among NREQ requesters.
// Define MULT_ARB_FIXED_PRI_EN for fixed (lowest-index) priority; default is round-robin.
module mult_arbiter #(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_x,
    input  logic [32*NREQ-1:0]   req_y,
    output logic [NREQ-1:0]      req_ready,
    output logic                 mul_en,
    output logic [31:0]          mul_x,
    output logic [31:0]          mul_y,
    input  logic [63:0]          mul_out,
    output logic [NREQ-1:0]      resp_valid,
    output logic [2:0]           resp_id,
    output logic [63:0]          resp_data,
    output logic                 busy
);

    logic [2:0]       win;
    logic             found;
    logic             hs;
    logic [31:0]      sel_x;
    logic [31:0]      sel_y;
    logic [NREQ-1:0]  last_onehot;
    logic [MUL_LAT:0] tag_vld;
    logic [2:0]       tag_id [MUL_LAT+1];

`ifndef MULT_ARB_FIXED_PRI_EN
    logic [2:0] ptr;
`endif

    // NOTE: every combinational output gets a default before the search loop,
    // so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
`ifdef MULT_ARB_FIXED_PRI_EN
            idx = k;
`else
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
`endif
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = 3'(idx);
            end
        end
    end

    always_comb begin
        req_ready   = '0;
        sel_x       = '0;
        sel_y       = '0;
        last_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i]   = mul_en && found && (win == 3'(i));
            last_onehot[i] = (tag_id[MUL_LAT] == 3'(i));
            if (win == 3'(i)) begin
                sel_x = req_x[32*i +: 32];
                sel_y = req_y[32*i +: 32];
            end
        end
    end

    // Grant is only ever raised on a valid requester, so any grant is a handshake.
    assign hs   = |req_ready;
    assign busy = |tag_vld;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, which is what makes the tag shift register work.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_en     <= 1'b0;
            mul_x      <= '0;
            mul_y      <= '0;
            tag_vld    <= '0;
            resp_valid <= '0;
            resp_id    <= '0;
            resp_data  <= '0;
            // NOTE: the tag ids are a small register array, not a RAM, so
            // clearing them in reset is cheap and keeps resp_id deterministic.
            for (int s = 0; s <= MUL_LAT; s++) tag_id[s] <= '0;
        end else begin
            mul_en     <= 1'b1;
            tag_vld[0] <= hs;
            tag_id[0]  <= win;
            for (int s = 1; s <= MUL_LAT; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_id[s]  <= tag_id[s-1];
            end
            if (hs) begin
                mul_x <= sel_x;
                mul_y <= sel_y;
            end
            if (tag_vld[MUL_LAT]) begin
                resp_valid <= last_onehot;
                resp_id    <= tag_id[MUL_LAT];
                resp_data  <= mul_out;
            end else begin
                resp_valid <= '0;
            end
        end
    end

`ifndef MULT_ARB_FIXED_PRI_EN
    // Pointer moves just past the winner so the next search starts at its neighbour.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (hs) begin
            ptr <= (win == 3'(NREQ-1)) ? 3'd0 : win + 3'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter with a behavioural pipelined multiplier.
module tb_mult_arbiter;

    localparam int NREQ    = 4;
    localparam int MUL_LAT = 2;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] p;
    } op_t;

    typedef struct packed {
        logic [2:0]  id;
        logic [63:0] p;
        logic [31:0] cyc;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [32*NREQ-1:0]  req_x = '0;
    logic [32*NREQ-1:0]  req_y = '0;
    logic [NREQ-1:0]     req_ready;
    logic                mul_en;
    logic [31:0]         mul_x;
    logic [31:0]         mul_y;
    logic [63:0]         mul_out;
    logic [NREQ-1:0]     resp_valid;
    logic [2:0]          resp_id;
    logic [63:0]         resp_data;
    logic                busy;

    mult_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_ready  (req_ready),
        .mul_en     (mul_en),
        .mul_x      (mul_x),
        .mul_y      (mul_y),
        .mul_out    (mul_out),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ea;
        logic signed [63:0] eb;
        ea = $signed(a);
        eb = $signed(b);
        return ea * eb;
    endfunction

    // External multiplier: product appears on mul_out MUL_LAT edges after operands.
    logic [63:0] mpipe [MUL_LAT];
    always @(posedge clk) begin
        mpipe[0] <= mul64(mul_x, mul_y);
        for (int k = 1; k < MUL_LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mul_out = mpipe[MUL_LAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    op_t             pend [NREQ][$];
    exp_t            sb [$];
    int              grant_log [$];
    logic [NREQ-1:0] hs_q = '0;
    exp_t            mon_e;

    // Monitor: sample away from the edge; a handshake seen now completes on the next edge.
    always @(negedge clk) begin
        if (resp_valid != '0) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 64'(resp_valid), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("resp_cycle", 64'(cyc), 64'(mon_e.cyc));
                check("resp_id", 64'(resp_id), 64'(mon_e.id));
                check("resp_onehot", 64'(resp_valid), 64'(1) << mon_e.id);
                check("resp_data", resp_data, mon_e.p);
            end
        end else if (sb.size() != 0 && 32'(cyc) > sb[0].cyc) begin
            mon_e = sb.pop_front();
            check("resp_missing", 64'(cyc), 64'(mon_e.cyc));
        end
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i] && pend[i].size() != 0) begin
                sb.push_back('{id: 3'(i), p: pend[i][0].p, cyc: 32'(cyc + MUL_LAT + 2)});
                grant_log.push_back(i);
            end
        end
        hs_q <= req_valid & req_ready;
    end

    // Requester model: holds operands until granted, then presents its next op.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (hs_q[i] && pend[i].size() != 0) void'(pend[i].pop_front());
            req_valid[i] = (pend[i].size() != 0);
            req_x[32*i +: 32] = (pend[i].size() != 0) ? pend[i][0].x : 32'd0;
            req_y[32*i +: 32] = (pend[i].size() != 0) ? pend[i][0].y : 32'd0;
        end
    end

    task automatic send(input int id, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] p);
        pend[id].push_back('{x: x, y: y, p: p});
    endtask

    task automatic send_rand(input int id);
        logic [31:0] x;
        logic [31:0] y;
        x = $urandom;
        y = $urandom;
        send(id, x, y, mul64(x, y));
    endtask

    task automatic wait_grants(input int n);
        int t = 0;
        while (grant_log.size() < n && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("grant_timeout", 64'(grant_log.size()), 64'(n));
    endtask

    function automatic bit all_pend_empty();
        for (int i = 0; i < NREQ; i++) if (pend[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || !all_pend_empty()) && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_mul_en"}, 64'(mul_en), 64'd0);
        check({tag, "_mul_x"}, 64'(mul_x), 64'd0);
        check({tag, "_mul_y"}, 64'(mul_y), 64'd0);
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check({tag, "_resp_id"}, 64'(resp_id), 64'd0);
        check({tag, "_resp_data"}, resp_data, 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    int rot_exp [8];

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mul_en_after_reset", 64'(mul_en), 64'd1);

        // Single request from requester 0.
        @(negedge clk);
        grant_log.delete();
        send(0, 32'h0008_7234, 32'h0000_0348, 64'h0000_0000_1BB6_BAA0);
        wait_grants(1);
        @(posedge clk);
        #1;
        check("mul_x_load", 64'(mul_x), 64'h0008_7234);
        check("mul_y_load", 64'(mul_y), 64'h0000_0348);
        check("busy_inflight", 64'(busy), 64'd1);
        drain();

        // Signed operands, requester 2 alone back-to-back.
        grant_log.delete();
        send(2, 32'hB887_CAAF, 32'h5064_7236, 64'hE98E_647F_4142_AEEA);
        send(2, 32'hFFFF_FEFD, 32'hFFFF_FEFD, 64'h0000_0000_0001_0609);
        wait_grants(2);
        check("solo_grant0", 64'(grant_log[0]), 64'd2);
        check("solo_grant1", 64'(grant_log[1]), 64'd2);
        drain();

        // Edge operands on requester 3 (round-robin pointer wraps to 0 afterwards).
        send(3, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
        send(3, 32'h0000_0000, 32'h5064_7236, 64'h0);
        send(3, 32'hB887_CAAF, 32'h0000_0001, 64'hFFFF_FFFF_B887_CAAF);
        drain();

        // Contention: all four requesters in the same cycle.
        grant_log.delete();
        for (int i = 0; i < NREQ; i++) send_rand(i);
        wait_grants(NREQ);
        for (int i = 0; i < NREQ; i++) check($sformatf("contend_grant%0d", i),
                                             64'(grant_log[i]), 64'(i));
        drain();

        // Move the pointer to 2, then rotate between requesters 1 and 3.
        send_rand(1);
        drain();
        grant_log.delete();
        for (int k = 0; k < 4; k++) begin
            send_rand(1);
            send_rand(3);
        end
`ifdef MULT_ARB_FIXED_PRI_EN
        rot_exp = '{1, 1, 1, 1, 3, 3, 3, 3};
`else
        rot_exp = '{3, 1, 3, 1, 3, 1, 3, 1};
`endif
        wait_grants(8);
        for (int k = 0; k < 8; k++) check($sformatf("rotate_grant%0d", k),
                                           64'(grant_log[k]), 64'(rot_exp[k]));
        drain();

        // Reset while two operations are in flight.
        grant_log.delete();
        send_rand(0);
        send_rand(1);
        wait_grants(2);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        #1;
        check_all_zero("midreset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        check("post_reset_busy", 64'(busy), 64'd0);
        check("post_reset_resp", 64'(resp_valid), 64'd0);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter that shares one pipelined signed 32x32->64 Wallace-tree multiplier (integrationMult) between NREQ requesters. Accepts at most one operand pair per cycle through per-requester valid/ready handshakes and drives the multiplier's operand and enable inputs. Tracks each in-flight operation's requester id in a tag pipeline matched to the multiplier latency, and returns every product with a one-cycle valid pulse to the originating requester. Sits between the requester blocks and the multiplier instance in the arithmetic subsystem.

## Interface
- NREQ, 4: number of requesters (2..8)
- MUL_LAT, 2: multiplier latency in cycles, operands presented to product valid on mul_out
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_x  in  32*NREQ  signed multiplicand, requester i at bits [32i+31:32i]
- req_y  in  32*NREQ  signed multiplier, same packing
- req_ready  out  NREQ  one-hot grant; handshake when req_valid[i] & req_ready[i]
- mul_en  out  1  multiplier enable
- mul_x  out  32  registered operand to multiplier x
- mul_y  out  32  registered operand to multiplier y
- mul_out  in  64  signed product from multiplier
- resp_valid  out  NREQ  one-hot, one-cycle product-valid pulse
- resp_id  out  3  index of requester owning resp_data
- resp_data  out  64  registered signed product
- busy  out  1  any operation in flight

## Operation
- Reset values: req_ready=0, mul_en=0, mul_x=0, mul_y=0, resp_valid=0, resp_id=0, resp_data=0, busy=0; tag pipeline cleared; round-robin pointer = 0.
- mul_en registered; goes 1 on the first edge after reset deasserts and stays 1 (multiplier never stalled).
- Arbitration (combinational from req_valid and pointer): search starts at pointer, wraps modulo NREQ; first asserted req_valid index wins; req_ready is one-hot at winner, all-zero if no req_valid. req_ready is forced 0 while mul_en=0.
- On handshake edge: mul_x/mul_y load winner's operands; tag stage 0 loads {valid=1, id=winner}; pointer = winner+1 mod NREQ. No handshake: mul_x/mul_y hold, tag stage 0 valid=0, pointer holds.
- Tag pipeline: MUL_LAT+1 stages, shifts every cycle. When last stage valid: resp_data <= mul_out, resp_id <= tag id, resp_valid <= onehot(id). Otherwise resp_valid <= 0, resp_data/resp_id hold.
- No response backpressure: requesters must consume resp_valid pulses.
- Arithmetic: full signed two's-complement product, 64 bits, no truncation or saturation; arbiter does not modify data.
- busy = OR of all tag-stage valid bits.
- Requesters must hold req_x/req_y stable while req_valid=1 and req_ready=0; the arbiter must not drop or duplicate requests.

## Timing
- Throughput: one accepted request per cycle, back-to-back across any requesters.
- Latency: handshake at edge E -> resp_valid high in cycle following edge E+MUL_LAT+1 (3 edges at default).
- Responses return in acceptance order; single requester gets every cycle when alone (pointer wraps to it).
- Simultaneous requests: strict rotation; with all NREQ asserting continuously, each is granted exactly once per NREQ cycles.
- Reset mid-operation: all in-flight tags discarded, no resp_valid for them after reset; mul_out contents ignored.
- Response and new grant in the same cycle are independent.

## Configuration
- MULT_ARB_FIXED_PRI_EN defined: fixed priority, lowest index wins; pointer logic removed, starvation of high indices allowed.
- Undefined (default): round-robin as above.

## Test plan
- Single request: requester 0 x=0x87234, y=0x348, accepted at edge E -> resp_valid=4'b0001, resp_id=0, resp_data=0x1BB6BAA0 after edge E+3.
- Signed: requester 2 x=0xB887CAAF, y=0x50647236 -> resp_data=0xE98E647F4142AEEA, resp_id=2; x=0xFFFFFEFD, y=0xFFFFFEFD -> 0x10609.
- Contention: all four requesters valid from same cycle -> grants 0,1,2,3 on consecutive cycles, responses in same order on consecutive cycles, each product correct.
- Rotation: requesters 1 and 3 valid continuously after pointer=2 -> grant sequence 3,1,3,1; with MULT_ARB_FIXED_PRI_EN -> 1,1,1,1.
- Reset mid-flight: two requests accepted, reset asserted one cycle later -> all outputs 0 immediately, no resp_valid after release, busy=0.
- Edge operands: x=0x7FFFFFFF, y=0x7FFFFFFF -> 0x3FFFFFFF00000001; x=0, y=0x50647236 -> 0; x=0xB887CAAF, y=1 -> 0xFFFFFFFFB887CAAF.
